// File: rtl/gyro_pkg.sv
// -----------------------------------------------------------------------------
// gyro_pkg
//   Shared definitions for the gyro demodulator and the filter stage behind it.
//   - gyro_state_e : demodulator FSM encoding (IDLE/SYNC/BLANK/ACCUM, 2 bits)
//   - wide_t       : 64-bit signed working type for the arithmetic helpers
//   - clip_to      : clamp a wide value to a w-bit signed range, flag on clip
//   - sat_add      : wide add followed by clamp to a w-bit signed range
//   The helpers take the target width as an argument so that one pair of
//   functions serves every stage regardless of its own parameter set; callers
//   cast the returned wide value down to their register width.
// -----------------------------------------------------------------------------
package gyro_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_BLANK = 2'd2,
    ST_ACCUM = 2'd3
  } gyro_state_e;

  localparam int WIDE_W = 64;
  typedef logic signed [WIDE_W-1:0] wide_t;

  // Clamp v into [-2^(w-1), 2^(w-1)-1]; w must be in 2..63.
  function automatic wide_t clip_to(input wide_t v, input int w, output logic clipped);
    wide_t hi;
    wide_t lo;
    wide_t res;
    hi      = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo      = -hi - wide_t'(1);
    clipped = 1'b0;
    res     = v;
    if (v > hi) begin
      res     = hi;
      clipped = 1'b1;
    end else if (v < lo) begin
      res     = lo;
      clipped = 1'b1;
    end
    return res;
  endfunction

  // Saturating add; operands are already w-bit values sign-extended to wide_t,
  // so the wide sum itself can never overflow for w <= 62.
  function automatic wide_t sat_add(input wide_t a, input wide_t b, input int w,
                                    output logic clipped);
    return clip_to(a + b, w, clipped);
  endfunction

endpackage

// File: rtl/gyro_shift_sat.sv
// -----------------------------------------------------------------------------
// gyro_shift_sat
//   Combinational output stage: arithmetic right shift of the window
//   accumulator followed by a clamp to the OUT_W-bit measurement range.
//   Ports:
//     acc_i    in  ACC_W  signed accumulator value
//     shift_i  in  5      right-shift amount (arithmetic)
//     meas_o   out OUT_W  shifted and clamped result
//     clip_o   out 1      high when the clamp changed the value
// -----------------------------------------------------------------------------
module gyro_shift_sat
  import gyro_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int OUT_W = 10
) (
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic        [4:0]       shift_i,
  output logic signed [OUT_W-1:0] meas_o,
  output logic                    clip_o
);

  wide_t acc_wide;
  wide_t shifted;

  always_comb begin
    // Casting a signed value to the wide signed type sign-extends it.
    acc_wide = wide_t'(acc_i);
    shifted  = acc_wide >>> shift_i;
    clip_o   = 1'b0;
    meas_o   = OUT_W'(clip_to(shifted, OUT_W, clip_o));
  end

endmodule

// File: rtl/gyro_demod_decim.sv
// -----------------------------------------------------------------------------
// gyro_demod_decim
//   Square-wave demodulator / decimator in front of the Kalman filter.
//   Raw photodetector samples are sign-corrected by the modulation half,
//   the first SKIP samples after every modulation edge are blanked, and the
//   rest are summed over 2^PER_LOG2 modulation periods. At the end of each
//   window the sum is shifted, clamped and presented on o_meas, where it is
//   held until the next window closes.
//
//   Sample strobe: i_adc_vld is a one-way valid with no backpressure. Every
//   clock with i_adc_vld=1 carries exactly one sample in i_adc_data together
//   with its modulation half in i_mod_sign; on clocks with i_adc_vld=0 both
//   are ignored and nothing advances. The only exception is i_en=0, which
//   forces IDLE on the next clock whether or not a sample is present.
//
//   Ports:
//     i_clk        in   1      system clock
//     i_rst_n      in   1      asynchronous active-low reset
//     i_adc_data   in   ADC_W  signed ADC sample
//     i_adc_vld    in   1      sample strobe
//     i_mod_sign   in   1      1 = positive modulation half, 0 = negative half
//     i_en         in   1      block enable
//     i_shift      in   5      output right-shift, sampled when a window closes
//     o_meas       out  OUT_W  signed measurement, held between updates
//     o_meas_vld   out  1      one-clock strobe when o_meas updates
//     o_sat        out  1      accumulator or output clamp hit in that window
//     o_short      out  1      sticky: a half-period ended inside its blanking
//     o_dbg_state  out  2      current FSM state, for observation only
// -----------------------------------------------------------------------------
module gyro_demod_decim
  import gyro_pkg::*;
#(
  parameter int ADC_W    = 14,
  parameter int OUT_W    = 10,
  parameter int ACC_W    = 32,
  parameter int SKIP     = 4,
  parameter int PER_LOG2 = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic signed [ADC_W-1:0] i_adc_data,
  input  logic                    i_adc_vld,
  input  logic                    i_mod_sign,
  input  logic                    i_en,
  input  logic        [4:0]       i_shift,
  output logic signed [OUT_W-1:0] o_meas,
  output logic                    o_meas_vld,
  output logic                    o_sat,
  output logic                    o_short,
  output gyro_state_e             o_dbg_state
);

  // One extra bit so PER_LOG2=0 still has a legal counter.
  localparam int                CNT_W      = PER_LOG2 + 1;
  localparam logic [CNT_W-1:0]  PER_LAST   = CNT_W'((1 << PER_LOG2) - 1);
  localparam int                BLK_W      = (SKIP < 2) ? 1 : $clog2(SKIP + 1);
  // The edge sample itself is the first blanked sample, so the counter holds
  // the number of blanked samples still to come after the edge.
  localparam int                BLK_LOAD_I = (SKIP > 0) ? SKIP - 1 : 0;
  localparam logic [BLK_W-1:0]  BLK_LOAD   = BLK_W'(BLK_LOAD_I);

  // Registers
  gyro_state_e              state_q,     state_d;
  logic                     prev_sign_q, prev_sign_d;
  logic signed [ACC_W-1:0]  acc_q,       acc_d;
  logic                     sat_q,       sat_d;
  logic        [CNT_W-1:0]  per_cnt_q,   per_cnt_d;
  logic        [BLK_W-1:0]  blank_cnt_q, blank_cnt_d;
  logic signed [OUT_W-1:0]  meas_q,      meas_d;
  logic                     meas_vld_q,  meas_vld_d;
  logic                     osat_q,      osat_d;
  logic                     short_q,     short_d;

  // Combinational helpers
  logic                     in_run_w;
  logic                     edge_w;
  logic                     rise_w;
  logic                     dump_w;
  logic                     open_half;
  wide_t                    term_w;
  wide_t                    base_w;
  logic signed [ACC_W-1:0]  acc_sum_w;
  logic                     add_clip_w;
  logic signed [OUT_W-1:0]  res_w;
  logic                     res_clip_w;

  assign in_run_w = (state_q == ST_BLANK) || (state_q == ST_ACCUM);
  assign edge_w   = (i_mod_sign != prev_sign_q);
  assign rise_w   = edge_w & i_mod_sign;
  // The closing rising edge of a window: the last period counted so far was
  // period 2^PER_LOG2 - 1, and this edge completes the final one.
  assign dump_w   = i_en & i_adc_vld & in_run_w & rise_w & (per_cnt_q == PER_LAST);

  // Single saturating adder. The base is zero whenever the current sample is
  // the first one of a fresh window (opening edge in SYNC or closing edge),
  // so with SKIP=0 that edge sample seeds the next window.
  always_comb begin
    term_w     = i_mod_sign ? wide_t'(i_adc_data) : -wide_t'(i_adc_data);
    base_w     = (in_run_w && !dump_w) ? wide_t'(acc_q) : '0;
    add_clip_w = 1'b0;
    acc_sum_w  = ACC_W'(sat_add(base_w, term_w, ACC_W, add_clip_w));
  end

  gyro_shift_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_shift_sat (
    .acc_i   (acc_q),
    .shift_i (i_shift),
    .meas_o  (res_w),
    .clip_o  (res_clip_w)
  );

  always_comb begin
    state_d     = state_q;
    prev_sign_d = prev_sign_q;
    acc_d       = acc_q;
    sat_d       = sat_q;
    per_cnt_d   = per_cnt_q;
    blank_cnt_d = blank_cnt_q;
    meas_d      = meas_q;
    meas_vld_d  = 1'b0;
    osat_d      = osat_q;
    short_d     = short_q;
    open_half   = 1'b0;

    if (!i_en) begin
      // Disable drops the window at once; o_meas / o_sat keep their values.
      state_d     = ST_IDLE;
      acc_d       = '0;
      sat_d       = 1'b0;
      per_cnt_d   = '0;
      blank_cnt_d = '0;
      short_d     = 1'b0;
      if (i_adc_vld) begin
        prev_sign_d = i_mod_sign;
      end
    end else if (i_adc_vld) begin
      prev_sign_d = i_mod_sign;
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SYNC;
        end
        ST_SYNC: begin
          if (rise_w) begin
            acc_d     = '0;
            sat_d     = 1'b0;
            per_cnt_d = '0;
            open_half = 1'b1;
          end
        end
        ST_BLANK, ST_ACCUM: begin
          if (edge_w) begin
            // In BLANK the counter is always non-zero, so any edge here means
            // the previous half never got past its blanking interval.
            if (state_q == ST_BLANK) begin
              short_d = 1'b1;
            end
            if (rise_w) begin
              per_cnt_d = dump_w ? '0 : per_cnt_q + CNT_W'(1);
            end
            if (dump_w) begin
              meas_d     = res_w;
              osat_d     = sat_q | res_clip_w;
              meas_vld_d = 1'b1;
              acc_d      = '0;
              sat_d      = 1'b0;
            end
            open_half = 1'b1;
          end else if (state_q == ST_BLANK) begin
            blank_cnt_d = blank_cnt_q - BLK_W'(1);
            if (blank_cnt_q == BLK_W'(1)) begin
              state_d = ST_ACCUM;
            end
          end else begin
            acc_d = acc_sum_w;
            sat_d = sat_q | add_clip_w;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      // Start of a half-period: the edge sample is either the first blanked
      // sample or, with no blanking, the first accumulated one.
      if (open_half) begin
        if (SKIP == 0) begin
          acc_d       = acc_sum_w;
          sat_d       = sat_d | add_clip_w;
          blank_cnt_d = '0;
          state_d     = ST_ACCUM;
        end else begin
          blank_cnt_d = BLK_LOAD;
          state_d     = (SKIP == 1) ? ST_ACCUM : ST_BLANK;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      prev_sign_q <= 1'b0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      per_cnt_q   <= '0;
      blank_cnt_q <= '0;
      meas_q      <= '0;
      meas_vld_q  <= 1'b0;
      osat_q      <= 1'b0;
      short_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_sign_q <= prev_sign_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      per_cnt_q   <= per_cnt_d;
      blank_cnt_q <= blank_cnt_d;
      meas_q      <= meas_d;
      meas_vld_q  <= meas_vld_d;
      osat_q      <= osat_d;
      short_q     <= short_d;
    end
  end

  assign o_meas      = meas_q;
  assign o_meas_vld  = meas_vld_q;
  assign o_sat       = osat_q;
  assign o_short     = short_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_gyro_demod_decim.sv
// -----------------------------------------------------------------------------
// tb_gyro_demod_decim
//   Directed bench for gyro_demod_decim with SKIP=2, PER_LOG2=1 and 8 samples
//   per half-period. A sample-level reference model (position inside the
//   half-period, rising-edge count per window, plain integer sum) predicts the
//   outputs each clock; a compare process checks every clock, and each
//   scenario pins the model with hand-computed literal results.
// -----------------------------------------------------------------------------
module tb_gyro_demod_decim;

  localparam int ADC_W    = 14;
  localparam int OUT_W    = 10;
  localparam int ACC_W    = 32;
  localparam int SKIP     = 2;
  localparam int PER_LOG2 = 1;

  localparam longint OUT_MAX = (longint'(1) << (OUT_W - 1)) - 1;
  localparam longint OUT_MIN = -(longint'(1) << (OUT_W - 1));
  localparam longint ACC_MAX = (longint'(1) << (ACC_W - 1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) << (ACC_W - 1));

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic signed [ADC_W-1:0] i_adc_data = '0;
  logic                    i_adc_vld  = 1'b0;
  logic                    i_mod_sign = 1'b0;
  logic                    i_en       = 1'b0;
  logic [4:0]              i_shift    = 5'd0;
  logic signed [OUT_W-1:0] o_meas;
  logic                    o_meas_vld;
  logic                    o_sat;
  logic                    o_short;
  gyro_pkg::gyro_state_e   dbg_state;

  gyro_demod_decim #(
    .ADC_W    (ADC_W),
    .OUT_W    (OUT_W),
    .ACC_W    (ACC_W),
    .SKIP     (SKIP),
    .PER_LOG2 (PER_LOG2)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_adc_data  (i_adc_data),
    .i_adc_vld   (i_adc_vld),
    .i_mod_sign  (i_mod_sign),
    .i_en        (i_en),
    .i_shift     (i_shift),
    .o_meas      (o_meas),
    .o_meas_vld  (o_meas_vld),
    .o_sat       (o_sat),
    .o_short     (o_short),
    .o_dbg_state (dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  chk_en  = 1'b0;
  int  gap     = 0;
  bit  drv_sign = 1'b0;
  int  rise_cyc[$];
  int  st_cyc[$];
  logic [OUT_W-1:0] st_meas[$];
  logic st_sat[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  int     m_phase = 0;  // 0 idle, 1 waiting for rising edge, 2 window running
  int     m_half  = 0;  // samples seen in the current half, edge sample = 1
  int     m_rises = 0;  // rising edges seen since the window opened
  longint m_acc   = 0;
  bit     m_asat  = 1'b0;
  bit     m_short = 1'b0;
  bit     m_prev  = 1'b0;
  longint m_meas  = 0;
  bit     m_vld   = 1'b0;
  bit     m_sat   = 1'b0;

  function automatic void m_add(input longint x);
    m_acc = m_acc + x;
    if (m_acc > ACC_MAX) begin m_acc = ACC_MAX; m_asat = 1'b1; end
    if (m_acc < ACC_MIN) begin m_acc = ACC_MIN; m_asat = 1'b1; end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    longint d;
    longint x;
    longint r;
    bit     e;
    bit     clip;
    if (!rst_n) begin
      m_phase = 0; m_half = 0; m_rises = 0; m_acc = 0; m_asat = 1'b0;
      m_short = 1'b0; m_prev = 1'b0; m_meas = 0; m_vld = 1'b0; m_sat = 1'b0;
    end else begin
      m_vld = 1'b0;
      if (!i_en) begin
        m_phase = 0; m_half = 0; m_rises = 0; m_acc = 0; m_asat = 1'b0; m_short = 1'b0;
        if (i_adc_vld) m_prev = i_mod_sign;
      end else if (i_adc_vld) begin
        d = longint'(i_adc_data);
        x = i_mod_sign ? d : -d;
        e = (i_mod_sign != m_prev);
        if (m_phase == 0) begin
          m_phase = 1;
        end else if (m_phase == 1) begin
          if (e && i_mod_sign) begin
            m_phase = 2; m_acc = 0; m_asat = 1'b0; m_rises = 0; m_half = 1;
            if (SKIP == 0) m_add(x);
          end
        end else begin
          if (e) begin
            if (m_half < SKIP) m_short = 1'b1;
            if (i_mod_sign) begin
              m_rises++;
              if (m_rises == (1 << PER_LOG2)) begin
                r    = m_acc >>> i_shift;
                clip = (r > OUT_MAX) || (r < OUT_MIN);
                if (r > OUT_MAX) r = OUT_MAX;
                if (r < OUT_MIN) r = OUT_MIN;
                m_meas = r; m_sat = m_asat | clip; m_vld = 1'b1;
                m_rises = 0; m_acc = 0; m_asat = 1'b0;
              end
            end
            m_half = 1;
            if (SKIP == 0) m_add(x);
          end else begin
            m_half++;
            if (m_half > SKIP) m_add(x);
          end
        end
        m_prev = i_mod_sign;
      end
    end
  end

  // ---------------- compare / scoreboard ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("meas",     o_meas,     m_meas);
      check("meas_vld", o_meas_vld, m_vld);
      check("sat",      o_sat,      m_sat);
      check("short",    o_short,    m_short);
      if (o_meas_vld) begin
        st_cyc.push_back(cyc);
        st_meas.push_back(o_meas);
        st_sat.push_back(o_sat);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic sample(input bit s, input int d);
    @(negedge clk);
    i_adc_vld  = 1'b1;
    i_mod_sign = s;
    i_adc_data = ADC_W'(d);
    if (s && !drv_sign) rise_cyc.push_back(cyc);
    drv_sign = s;
    repeat (gap) begin
      @(negedge clk);
      i_adc_vld  = 1'b0;
      i_mod_sign = 1'($urandom_range(0, 1));
      i_adc_data = ADC_W'($urandom_range(0, 16383));
    end
  endtask

  task automatic quiet(input int n);
    repeat (n) begin
      @(negedge clk);
      i_adc_vld = 1'b0;
    end
  endtask

  task automatic half(input bit s, input int v, input int n);
    repeat (n) sample(s, v);
  endtask

  task automatic period(input int pv, input int nv, input int np);
    repeat (np) begin
      half(1'b1, pv, 8);
      half(1'b0, nv, 8);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_adc_vld = 1'b0;
    i_en      = 1'b0;
    #2 rst_n  = 1'b0;
    drv_sign  = 1'b0;
    @(negedge clk);
    #2 rst_n  = 1'b1;
  endtask

  task automatic start(input int sh);
    do_reset();
    gap     = 0;
    i_en    = 1'b1;
    i_shift = 5'(sh);
    rise_cyc.delete();
    st_cyc.delete();
    st_meas.delete();
    st_sat.delete();
    half(1'b0, -100, 3);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_meas",  o_meas, 0);
    check("rst_vld",   o_meas_vld, 0);
    check("rst_sat",   o_sat, 0);
    check("rst_short", o_short, 0);
    check("rst_state", dbg_state, gyro_pkg::ST_IDLE);

    // 1 nominal: 4 halves x 6 kept samples x 100 = 2400, >>>4 = 150
    start(4);
    period(100, -100, 3);
    quiet(4);
    check("t1_count", st_meas.size(), 1);
    if (st_meas.size() >= 1) begin
      check("t1_meas", $signed(st_meas[0]), 150);
      check("t1_sat",  st_sat[0], 0);
      check("t1_lat",  st_cyc[0], rise_cyc[2] + 1);
    end

    // 2 clip: -24000 clamps to -512; next window -24000>>>6 = -375
    start(0);
    period(-1000, 1000, 3);
    i_shift = 5'd6;
    period(-1000, 1000, 2);
    quiet(4);
    check("t2_count", st_meas.size(), 2);
    if (st_meas.size() >= 2) begin
      check("t2_meas0", $signed(st_meas[0]), -512);
      check("t2_sat0",  st_sat[0], 1);
      check("t2_meas1", $signed(st_meas[1]), -375);
      check("t2_sat1",  st_sat[1], 0);
    end

    // 3 short half: window sums 600+600+600+0 = 1800, >>>4 = 112
    start(4);
    period(100, -100, 1);
    half(1'b1, 100, 8);
    half(1'b0, -100, 1);
    period(100, -100, 1);
    quiet(3);
    check("t3_short", o_short, 1);
    check("t3_count", st_meas.size(), 1);
    if (st_meas.size() >= 1) check("t3_meas", $signed(st_meas[0]), 112);
    period(100, -100, 1);
    quiet(3);
    check("t3_sticky", o_short, 1);

    // 4 enable drop mid-window, then resynchronise
    start(4);
    period(100, -100, 3);
    half(1'b1, 100, 8);
    half(1'b0, -100, 4);
    @(negedge clk);
    i_en = 1'b0;
    half(1'b0, -100, 3);
    half(1'b1, 100, 3);
    quiet(2);
    check("t4_hold",  o_meas, 150);
    check("t4_state", dbg_state, gyro_pkg::ST_IDLE);
    check("t4_nostb", st_meas.size(), 1);
    @(negedge clk);
    i_en = 1'b1;
    rise_cyc.delete();
    half(1'b0, -100, 3);
    period(100, -100, 3);
    quiet(4);
    check("t4_count", st_meas.size(), 2);
    if (st_meas.size() >= 2) begin
      check("t4_meas", $signed(st_meas[1]), 150);
      check("t4_lat",  st_cyc[1], rise_cyc[2] + 1);
    end

    // 5 sparse strobes: one sample every 7th clock
    start(4);
    gap = 6;
    period(100, -100, 3);
    gap = 0;
    quiet(4);
    check("t5_count", st_meas.size(), 1);
    if (st_meas.size() >= 1) begin
      check("t5_meas", $signed(st_meas[0]), 150);
      check("t5_lat",  st_cyc[0], rise_cyc[2] + 1);
    end

    // 6 asynchronous reset in the middle of accumulation
    start(4);
    period(100, -100, 3);
    half(1'b1, 100, 4);
    @(negedge clk);
    i_adc_vld = 1'b0;
    check("t6_pre_meas",  o_meas, 150);
    check("t6_pre_state", dbg_state, gyro_pkg::ST_ACCUM);
    #2 rst_n = 1'b0;
    drv_sign = 1'b0;
    #1;
    check("t6_meas",  o_meas, 0);
    check("t6_vld",   o_meas_vld, 0);
    check("t6_sat",   o_sat, 0);
    check("t6_short", o_short, 0);
    check("t6_state", dbg_state, gyro_pkg::ST_IDLE);
    @(negedge clk);
    #2 rst_n = 1'b1;
    quiet(10);
    check("t6_nostb", st_meas.size(), 1);
    check("t6_idle",  dbg_state, gyro_pkg::ST_IDLE);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
